// File: rtl/ahbl_imem_dmem_arbiter.sv
// ahbl_imem_dmem_arbiter
// Shares one AHB-Lite master port between an instruction fetch port (read
// only) and a data port. Each upstream port has a one-deep stage that holds
// an address phase the shared bus could not take, and replays it later.
// Data accesses win over fetches until D_STREAK consecutive data
// acceptances have starved a waiting fetch. The fetch is then let through.
module ahbl_imem_dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int D_STREAK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       imem_htrans,
  input  logic [WIDTH-1:0] imem_haddr,
  input  logic [2:0]       imem_hsize,
  input  logic [3:0]       imem_hprot,
  output logic             imem_hready,
  output logic [WIDTH-1:0] imem_hrdata,
  output logic             imem_hresp,
  input  logic [1:0]       dmem_htrans,
  input  logic [WIDTH-1:0] dmem_haddr,
  input  logic [2:0]       dmem_hsize,
  input  logic [3:0]       dmem_hprot,
  input  logic             dmem_hwrite,
  input  logic [WIDTH-1:0] dmem_hwdata,
  output logic             dmem_hready,
  output logic [WIDTH-1:0] dmem_hrdata,
  output logic             dmem_hresp,
  output logic [1:0]       bus_htrans,
  output logic [WIDTH-1:0] bus_haddr,
  output logic [2:0]       bus_hsize,
  output logic [3:0]       bus_hprot,
  output logic             bus_hwrite,
  output logic [WIDTH-1:0] bus_hwdata,
  output logic [2:0]       bus_hburst,
  output logic             bus_hmastlock,
  input  logic             bus_hready,
  input  logic [WIDTH-1:0] bus_hrdata,
  input  logic             bus_hresp
);

  localparam int              SW         = $clog2(D_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(D_STREAK);
  localparam logic            OWN_I      = 1'b0;
  localparam logic            OWN_D      = 1'b1;

  // imem replay stage
  logic             i_pend_q, i_pend_d;
  logic [WIDTH-1:0] i_addr_q, i_addr_d;
  logic [2:0]       i_size_q, i_size_d;
  logic [3:0]       i_prot_q, i_prot_d;

  // dmem replay stage, including write data caught in the master's data phase
  logic             d_pend_q, d_pend_d;
  logic [WIDTH-1:0] d_addr_q, d_addr_d;
  logic [2:0]       d_size_q, d_size_d;
  logic [3:0]       d_prot_q, d_prot_d;
  logic             d_write_q, d_write_d;
  logic             wcap_q, wcap_d;
  logic [WIDTH-1:0] pend_wdata_q, pend_wdata_d;

  // bus data-phase tracking and arbitration state
  logic             dph_valid_q, dph_valid_d;
  logic             dph_owner_q, dph_owner_d;
  logic             dph_replay_q, dph_replay_d;
  logic             sel_q, sel_d;
  logic             lock_q, lock_d;
  logic [SW-1:0]    streak_q, streak_d;

  logic i_rdy, d_rdy;
  logic i_live, d_live;
  logic i_elig, d_elig;
  logic sel_any, sel, src_pend;
  logic accept, i_cap, d_cap;

  // htrans[0] (SEQ vs NONSEQ) is irrelevant: every transfer goes out as NONSEQ
  logic unused_htrans0;
  assign unused_htrans0 = imem_htrans[0] ^ dmem_htrans[0];

  assign bus_hburst    = 3'b000;
  assign bus_hmastlock = 1'b0;
  assign imem_hready   = i_rdy;
  assign dmem_hready   = d_rdy;

  // Port ready, eligibility, source selection and the shared address phase
  always_comb begin
    i_rdy = 1'b1;
    if (i_pend_q)                                 i_rdy = 1'b0;
    else if (dph_valid_q && dph_owner_q == OWN_I) i_rdy = bus_hready;
    d_rdy = 1'b1;
    if (d_pend_q)                                 d_rdy = 1'b0;
    else if (dph_valid_q && dph_owner_q == OWN_D) d_rdy = bus_hready;

    i_live = i_rdy & imem_htrans[1];
    d_live = d_rdy & dmem_htrans[1];
    i_elig = i_pend_q | i_live;
    d_elig = d_pend_q | d_live;

    // A held (waited) address phase must stay on the same port until taken
    sel_any = 1'b0;
    sel     = OWN_D;
    if (lock_q) begin
      sel_any = 1'b1;
      sel     = sel_q;
    end else if (i_elig && (!d_elig || streak_q >= STREAK_MAX)) begin
      sel_any = 1'b1;
      sel     = OWN_I;
    end else if (d_elig) begin
      sel_any = 1'b1;
      sel     = OWN_D;
    end
    src_pend = (sel == OWN_I) ? i_pend_q : d_pend_q;

    bus_htrans = 2'b00;
    bus_haddr  = '0;
    bus_hsize  = 3'b000;
    bus_hprot  = 4'b0000;
    bus_hwrite = 1'b0;
    if (sel_any) begin
      bus_htrans = 2'b10;
      if (sel == OWN_I) begin
        bus_haddr = i_pend_q ? i_addr_q : imem_haddr;
        bus_hsize = i_pend_q ? i_size_q : imem_hsize;
        bus_hprot = i_pend_q ? i_prot_q : imem_hprot;
      end else begin
        bus_haddr  = d_pend_q ? d_addr_q  : dmem_haddr;
        bus_hsize  = d_pend_q ? d_size_q  : dmem_hsize;
        bus_hprot  = d_pend_q ? d_prot_q  : dmem_hprot;
        bus_hwrite = d_pend_q ? d_write_q : dmem_hwrite;
      end
    end
  end

  // Data-phase routing: write data toward the bus, responses to the owner
  always_comb begin
    bus_hwdata  = '0;
    imem_hrdata = '0;
    imem_hresp  = 1'b0;
    dmem_hrdata = '0;
    dmem_hresp  = 1'b0;
    if (dph_valid_q) begin
      if (dph_owner_q == OWN_D) begin
        bus_hwdata  = dph_replay_q ? pend_wdata_q : dmem_hwdata;
        dmem_hrdata = bus_hrdata;
        dmem_hresp  = bus_hresp;
      end else begin
        imem_hrdata = bus_hrdata;
        imem_hresp  = bus_hresp;
      end
    end
  end

  // Next-state: accept, capture into the replay stages, lock and streak
  always_comb begin
    accept = bus_hready & sel_any;
    i_cap  = i_live & (!(sel_any && sel == OWN_I) | !bus_hready);
    d_cap  = d_live & (!(sel_any && sel == OWN_D) | !bus_hready);

    i_pend_d     = i_pend_q;
    i_addr_d     = i_addr_q;
    i_size_d     = i_size_q;
    i_prot_d     = i_prot_q;
    d_pend_d     = d_pend_q;
    d_addr_d     = d_addr_q;
    d_size_d     = d_size_q;
    d_prot_d     = d_prot_q;
    d_write_d    = d_write_q;
    wcap_d       = 1'b0;
    pend_wdata_d = pend_wdata_q;
    dph_valid_d  = dph_valid_q;
    dph_owner_d  = dph_owner_q;
    dph_replay_d = dph_replay_q;
    lock_d       = sel_any & !bus_hready;
    sel_d        = sel;
    streak_d     = streak_q;

    if (accept && sel == OWN_I) i_pend_d = 1'b0;
    if (accept && sel == OWN_D) d_pend_d = 1'b0;

    if (i_cap) begin
      i_pend_d = 1'b1;
      i_addr_d = imem_haddr;
      i_size_d = imem_hsize;
      i_prot_d = imem_hprot;
    end
    if (d_cap) begin
      d_pend_d  = 1'b1;
      d_addr_d  = dmem_haddr;
      d_size_d  = dmem_hsize;
      d_prot_d  = dmem_hprot;
      d_write_d = dmem_hwrite;
      wcap_d    = dmem_hwrite;
    end
    // The cycle after a write is captured is the master's first data cycle
    if (wcap_q) pend_wdata_d = dmem_hwdata;

    if (bus_hready) begin
      dph_valid_d = accept;
      if (accept) begin
        dph_owner_d  = sel;
        dph_replay_d = src_pend;
      end
    end

    if ((accept && sel == OWN_I) || !i_elig) begin
      streak_d = '0;
    end else if (accept && sel == OWN_D && streak_q < STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_pend_q     <= 1'b0;
      i_addr_q     <= '0;
      i_size_q     <= 3'b000;
      i_prot_q     <= 4'b0000;
      d_pend_q     <= 1'b0;
      d_addr_q     <= '0;
      d_size_q     <= 3'b000;
      d_prot_q     <= 4'b0000;
      d_write_q    <= 1'b0;
      wcap_q       <= 1'b0;
      pend_wdata_q <= '0;
      dph_valid_q  <= 1'b0;
      dph_owner_q  <= OWN_I;
      dph_replay_q <= 1'b0;
      sel_q        <= OWN_I;
      lock_q       <= 1'b0;
      streak_q     <= '0;
    end else begin
      i_pend_q     <= i_pend_d;
      i_addr_q     <= i_addr_d;
      i_size_q     <= i_size_d;
      i_prot_q     <= i_prot_d;
      d_pend_q     <= d_pend_d;
      d_addr_q     <= d_addr_d;
      d_size_q     <= d_size_d;
      d_prot_q     <= d_prot_d;
      d_write_q    <= d_write_d;
      wcap_q       <= wcap_d;
      pend_wdata_q <= pend_wdata_d;
      dph_valid_q  <= dph_valid_d;
      dph_owner_q  <= dph_owner_d;
      dph_replay_q <= dph_replay_d;
      sel_q        <= sel_d;
      lock_q       <= lock_d;
      streak_q     <= streak_d;
    end
  end

endmodule

// File: doc/ahbl_imem_dmem_arbiter.md
Name: ahbl_imem_dmem_arbiter

Overview:
- Shares one AHB-Lite master port between the bridge's imem (read-only) and dmem AHB master interfaces, so one Ibex core reaches a single-port memory/fabric.
- Each upstream port gets a one-deep input stage. An address phase accepted while the bus cannot take it is captured and replayed later.
- Arbitration: fixed data-over-instruction priority with a fetch anti-starvation counter. Responses route to the data-phase owner.

Parameters:
WIDTH, 32, address/data width
D_STREAK, 4, max consecutive dmem bus acceptances while imem waits (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
imem_htrans  in  2  imem transfer type; bit1=transfer
imem_haddr  in  WIDTH  imem address
imem_hsize  in  3  imem size
imem_hprot  in  4  imem prot
imem_hready  out  1  ready to imem master
imem_hrdata  out  WIDTH  read data to imem
imem_hresp  out  1  response to imem
dmem_htrans  in  2  dmem transfer type
dmem_haddr  in  WIDTH  dmem address
dmem_hsize  in  3  dmem size
dmem_hprot  in  4  dmem prot
dmem_hwrite  in  1  dmem write
dmem_hwdata  in  WIDTH  dmem write data (data phase)
dmem_hready  out  1  ready to dmem master
dmem_hrdata  out  WIDTH  read data to dmem
dmem_hresp  out  1  response to dmem
bus_htrans  out  2  shared bus trans: NONSEQ(2) or IDLE(0)
bus_haddr  out  WIDTH  shared address
bus_hsize  out  3  shared size
bus_hprot  out  4  shared prot
bus_hwrite  out  1  shared write (0 for imem)
bus_hwdata  out  WIDTH  shared write data
bus_hburst  out  3  constant 0 (SINGLE)
bus_hmastlock  out  1  constant 0
bus_hready  in  1  slave ready
bus_hrdata  in  WIDTH  slave read data
bus_hresp  in  1  slave response

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- Registers, all cleared by reset:
  - Per port: pend_q, plus captured addr/size/prot/write.
  - dmem wcap_q and pend_wdata_q.
  - dph_valid_q, dph_owner_q, dph_replay_q.
  - sel_q and lock_q.
  - streak_q (clog2(D_STREAK+1) bits).
- Port ready, per port p:
  - hready_p = 0 if pend_q[p].
  - Otherwise hready_p = bus_hready if dph_valid_q and dph_owner_q==p.
  - Otherwise hready_p = 1.
  - Reset: both 1, bus_htrans=IDLE, hrdata/hresp=0.
- Eligibility: port p is eligible if pend_q[p], or if (hready_p && htrans_p[1]) — the live transfer. Pend and live are mutually exclusive per port.
- Selection:
  - If lock_q, sel=sel_q.
  - Else imem is selected when imem is eligible and (dmem is not eligible or streak_q>=D_STREAK).
  - Otherwise dmem is selected when eligible.
  - Otherwise the bus is IDLE.
- Bus address phase: combinational from the selected source (pend regs if pend_q else live inputs); bus_htrans=2 when any source is selected.
- Accept = bus_hready && bus_htrans[1]:
  - dph_valid_q<=1, dph_owner_q<=sel, dph_replay_q<=(source was pend), pend_q[sel]<=0.
  - If bus_hready && no transfer, dph_valid_q<=0.
  - If bus_hready=0, the dph regs hold.
- Capture: at an edge where hready_p=1 and htrans_p[1]=1, the live transfer is captured when it is not selected or bus_hready=0. Effect: pend_q[p]<=1 and its addr/size/prot/write are stored.
- Lock: lock_q<=bus_htrans[1] && !bus_hready; sel_q<=sel. The held address phase is therefore identical (now from pend) until accepted. No IDLE or port switch is allowed mid-wait.
- Write data capture:
  - A dmem write capture sets wcap_q.
  - At the next edge, pend_wdata_q<=dmem_hwdata and wcap_q<=0 (first cycle of the master's data phase).
  - bus_hwdata = pend_wdata_q if dph_owner_q==dmem && dph_replay_q; else dmem_hwdata when the owner is dmem; else 0.
- Responses: the owner gets bus_hrdata/bus_hresp. The non-owner gets 0/0. Two-cycle ERROR responses are passed through unchanged.
- streak_q:
  - On a dmem accept while imem is eligible: saturating +1.
  - On an imem accept, or when imem is not eligible: 0.
- Throughput: an unloaded live transfer has zero added latency. A captured transfer costs at least one bus cycle before its address phase.

Test Plan:
- Idle bus, imem_htrans=2, haddr=0x100, bus_hready=1 → bus_haddr=0x100 in the same cycle; next cycle imem_hrdata=bus_hrdata, imem_hready=bus_hready.
- imem 0x100 and dmem read 0x2000 in the same cycle:
  - Cycle0: bus_haddr=0x2000, imem captured.
  - Cycle1: bus_haddr=0x100, imem_hready=0.
  - Cycle2: imem_hready=1 with data.
- imem address phase to 0x100 with bus_hready=0 for 2 cycles; dmem requests 0x2000 meanwhile → bus_haddr stays 0x100, htrans stays 2 until accepted; 0x2000 issues next.
- dmem write 0x3000 captured during an imem lock; hwdata=0xDEADBEEF in the next cycle, then 0x0 → replayed data phase drives bus_hwdata=0xDEADBEEF, bus_hwrite=1 in its address phase.
- dmem back-to-back reads and imem continuously requesting, D_STREAK=4 → bus accepts the pattern 4 dmem, 1 imem, repeating; neither port stalls forever.
- rst_n low mid-replay with bus_hready=0 → immediately both port hready=1, bus_htrans=0, pend/lock/streak cleared.
